// File: rtl/stepper_pkg.sv
// stepper_pkg: shared state codes, defaults and helpers for the step/direction generator
package stepper_pkg;
  localparam int DEF_MOTORS = 6;
  localparam int DEF_CNT_W = 10;
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0, SETUP = 3'd1, HIGH = 3'd2, LOW = 3'd3, DONE = 3'd4;
  function automatic logic is_onehot(input logic [31:0] v);
    return v != 0 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/step_pulse_gen_timer.sv
// step_timer: reloadable down-counter, expired is high while the count sits at zero
module step_timer #(
  parameter int W = 16
) (
  input  logic         sysclk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge sysclk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= load ? val : cnt - W'(cnt != '0);
  assign expired = cnt == '0;
endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: step/direction pulse generator for NUM_MOTORS stepper drivers
// STEP_PULSE_GEN_RAMP_EN adds a soft start: 4x half-period for pulses 1-4, 2x for pulses 5-8
module step_pulse_gen import stepper_pkg::*; #(
  parameter int NUM_MOTORS = DEF_MOTORS,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int HALF_PER   = 25000,
  parameter int DIV_W      = 16
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [CNT_W-1:0]      PulseNum,
  input  logic [NUM_MOTORS-1:0] DR,
  input  logic [NUM_MOTORS-1:0] Motor,
  input  logic                  Stop,
  output logic [NUM_MOTORS-1:0] PUL,
  output logic [NUM_MOTORS-1:0] DIR,
  output logic                  Busy,
  output logic                  Done,
  output logic [CNT_W-1:0]      Remain
);
  localparam logic [DIV_W-1:0] HP = DIV_W'(HALF_PER - 1);
  state_t state, nxt;
  logic [NUM_MOTORS-1:0] mot;
  logic go, load, expired;
  logic [DIV_W-1:0] val;
  assign go = state == IDLE && Start && !Stop && PulseNum != '0 && is_onehot(32'(Motor));
  always_comb
    nxt = state == IDLE ? (go ? SETUP : IDLE) :
          state == DONE ? IDLE :
          Stop          ? IDLE :
          !expired      ? state :
          state == SETUP ? HIGH :
          state == HIGH  ? LOW :
          Remain != '0   ? HIGH : DONE;
  // every state change reloads the timer, which is what clears the divider
  assign load = nxt != state;
`ifdef STEP_PULSE_GEN_RAMP_EN
  localparam logic [DIV_W-1:0] HP2 = DIV_W'(2 * HALF_PER - 1);
  localparam logic [DIV_W-1:0] HP4 = DIV_W'(4 * HALF_PER - 1);
  logic [CNT_W-1:0] emit;
  assign val = nxt == SETUP ? HP : emit < CNT_W'(4) ? HP4 : emit < CNT_W'(8) ? HP2 : HP;
  always_ff @(posedge sysclk or negedge rst)
    if (!rst) emit <= '0;
    else if (go) emit <= '0;
    else if (state == HIGH && nxt == LOW) emit <= emit + CNT_W'(1);
`else
  assign val = HP;
`endif
  step_timer #(.W(DIV_W)) u_timer (
    .sysclk (sysclk),
    .rst    (rst),
    .load   (load),
    .val    (val),
    .expired(expired)
  );
  // outputs lag the state by one cycle, except Busy which follows the next state
  always_ff @(posedge sysclk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      PUL    <= '0;
      DIR    <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Remain <= '0;
      mot    <= '0;
    end else begin
      state <= nxt;
      Busy  <= nxt != IDLE;
      Done  <= state == DONE;
      PUL   <= state == HIGH && !Stop ? mot : '0;
      if (go) begin
        mot    <= Motor;
        Remain <= PulseNum;
        DIR    <= DR;
      end else if (state == HIGH && nxt == LOW) Remain <= Remain - CNT_W'(1);
    end
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: directed self-checking bench for step_pulse_gen with HALF_PER=2
module tb_step_pulse_gen;
  import stepper_pkg::*;
  localparam int H = 2;
  logic sysclk = 0, rst = 0, Start = 0, Stop = 0;
  logic [9:0] PulseNum = '0, Remain;
  logic [5:0] DR = '0, Motor = '0, PUL, DIR;
  logic Busy, Done;
  int checks = 0, errors = 0;
  int rises, done_k, done_n;
  logic [5:0] pul_or, dir_var;
  logic busy_or;

  always #5 sysclk = ~sysclk;

  step_pulse_gen #(.HALF_PER(H)) dut (
    .sysclk  (sysclk),
    .rst     (rst),
    .Start   (Start),
    .PulseNum(PulseNum),
    .DR      (DR),
    .Motor   (Motor),
    .Stop    (Stop),
    .PUL     (PUL),
    .DIR     (DIR),
    .Busy    (Busy),
    .Done    (Done),
    .Remain  (Remain)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  // leaves the bench at the falling edge after the Start sample edge (cycle 0)
  task automatic issue(input logic [9:0] n, input logic [5:0] m, input logic [5:0] d);
    @(negedge sysclk);
    Start = 1; PulseNum = n; Motor = m; DR = d;
    @(negedge sysclk);
    Start = 0;
  endtask

  task automatic watch(input int k0, input int n, output int r, output int dk, output int dn,
                       output logic [5:0] po, output logic bo, output logic [5:0] dv);
    logic [5:0] prev, d0;
    prev = PUL; d0 = DIR; r = 0; dk = -1; dn = 0; po = '0; bo = 0; dv = '0;
    for (int k = k0 + 1; k <= k0 + n; k++) begin
      @(negedge sysclk);
      r += $countones(PUL & ~prev);
      prev = PUL;
      if (Done) begin
        dn++;
        if (dk < 0) dk = k;
      end
      po |= PUL; bo |= Busy; dv |= DIR ^ d0;
    end
  endtask

  initial begin
    #12;
    chk("rst_pul", PUL, 0);
    chk("rst_dir", DIR, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_remain", Remain, 0);
    rst = 1;

    issue(0, 6'b000100, 6'b111111);
    watch(0, 12, rises, done_k, done_n, pul_or, busy_or, dir_var);
    chk("zero_busy", busy_or, 0);
    chk("zero_pul", pul_or, 0);
    chk("zero_done", done_n, 0);
    chk("zero_dir", DIR, 0);
    issue(5, 6'b000011, 6'b111111);
    watch(0, 12, rises, done_k, done_n, pul_or, busy_or, dir_var);
    chk("twohot_busy", busy_or, 0);
    chk("twohot_pul", pul_or, 0);
    chk("twohot_done", done_n, 0);
    issue(5, 6'b000000, 6'b111111);
    watch(0, 12, rises, done_k, done_n, pul_or, busy_or, dir_var);
    chk("nomotor_busy", busy_or, 0);
    Stop = 1;
    issue(3, 6'b000100, 6'b000100);
    watch(0, 12, rises, done_k, done_n, pul_or, busy_or, dir_var);
    Stop = 0;
    chk("stopstart_busy", busy_or, 0);
    chk("stopstart_pul", pul_or, 0);

`ifdef STEP_PULSE_GEN_RAMP_EN
    begin
      int hw[16];
      int nh, run, dk;
      int exp_hw[10] = '{8, 8, 8, 8, 4, 4, 4, 4, 2, 2};
      nh = 0; run = 0; dk = -1;
      issue(10, 6'b001000, 6'b001000);
      for (int k = 1; k <= 115; k++) begin
        @(negedge sysclk);
        if (PUL[3]) run++;
        else if (run > 0) begin
          if (nh < 16) hw[nh] = run;
          nh++;
          run = 0;
        end
        if (Done && dk < 0) dk = k;
      end
      chk("ramp_count", nh, 10);
      for (int i = 0; i < 10; i++) chk($sformatf("ramp_hi%0d", i), (i < nh) ? hw[i] : -1, exp_hw[i]);
      chk("ramp_done_cycle", dk, 107);
    end
`else
    begin
      logic [31:0] hi_mask;
      hi_mask = 32'h0000_1998;
      issue(3, 6'b000100, 6'b000100);
      chk("move_dir", DIR, 6'b000100);
      chk("move_busy", Busy, 1);
      chk("move_remain", Remain, 3);
      for (int k = 1; k <= 18; k++) begin
        @(negedge sysclk);
        chk($sformatf("move_pul_c%0d", k), PUL, hi_mask[k] ? 6'b000100 : 6'b000000);
        chk($sformatf("move_done_c%0d", k), Done, k == 15);
        chk($sformatf("move_busy_c%0d", k), Busy, k < 15);
      end
      chk("move_remain_end", Remain, 0);
    end

    issue(5, 6'b000001, 6'b101010);
    repeat (7) @(negedge sysclk);
    chk("stop_pul_before", PUL, 6'b000001);
    Stop = 1;
    @(negedge sysclk);
    Stop = 0;
    chk("stop_pul", PUL, 0);
    chk("stop_busy", Busy, 0);
    chk("stop_remain", Remain, 4);
    chk("stop_dir", DIR, 6'b101010);
    watch(8, 12, rises, done_k, done_n, pul_or, busy_or, dir_var);
    chk("stop_no_done", done_n, 0);
    chk("stop_no_pul", pul_or, 0);

    issue(2, 6'b010000, {6{DIR_FWD}} | 6'b010001);
    Start = 1; PulseNum = 7; DR = {6{DIR_REV}}; Motor = 6'b000001;
    @(negedge sysclk);
    Start = 0;
    watch(1, 20, rises, done_k, done_n, pul_or, busy_or, dir_var);
    chk("busy_start_rises", rises, 2);
    chk("busy_start_done", done_k, 11);
    chk("busy_start_pul", pul_or, 6'b010000);
    chk("busy_start_dirvar", dir_var, 0);
    chk("busy_start_dir", DIR, 6'b010001);

    issue(4, 6'b000010, 6'b000010);
    repeat (3) @(negedge sysclk);
    chk("rst_mid_pul_before", PUL, 6'b000010);
    #1 rst = 0;
    #1;
    chk("rst_mid_pul", PUL, 0);
    chk("rst_mid_dir", DIR, 0);
    chk("rst_mid_busy", Busy, 0);
    chk("rst_mid_remain", Remain, 0);
    chk("rst_mid_done", Done, 0);
    @(negedge sysclk);
    rst = 1;
    issue(1, 6'b100000, 6'b100000);
    watch(0, 12, rises, done_k, done_n, pul_or, busy_or, dir_var);
    chk("after_rst_done", done_k, 7);
    chk("after_rst_rises", rises, 1);
    chk("after_rst_pul", pul_or, 6'b100000);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
